viterbi_static_tracker: RTL and testbench

Maintains the committed ("global static") symbol history of the Viterbi core. Each run step it selects the minimum-energy surviving state and commits that state's B_LEN newest symbols. It then convolves the committed history with the estimated channel to produce the static ISI contribution, which is added to the residual-error values for the next branch-metric stage.

---
 rtl/viterbi_pkg.sv | 12 +
 rtl/static_conv.sv | 33 +++
 rtl/viterbi_static_tracker.sv | 74 +++++++
 tb/tb_viterbi_static_tracker.sv | 185 ++++++++++++++++++
 4 files changed

// File: rtl/viterbi_pkg.sv
// viterbi_pkg: shared symbol type, saturation and static-tap offset helpers for the Viterbi core
package viterbi_pkg;
  typedef logic signed [1:0] symbol_t;
  function automatic int static_offset(input int b_len, input int h_depth, input int s_len);
    return b_len + h_depth + s_len;
  endfunction
  function automatic int saturate(input int v, input int w);
    int hi;
    hi = (1 <<< (w - 1)) - 1;
    return v > hi ? hi : v < -hi - 1 ? -hi - 1 : v;
  endfunction
endpackage

// File: rtl/static_conv.sv
// static_conv: convolves committed symbol history with the channel estimate, halves, saturates and adds rse
module static_conv
  import viterbi_pkg::*;
#(
  parameter int B_WIDTH           = 8,
  parameter int B_LEN             = 2,
  parameter int S_LEN             = 2,
  parameter int H_DEPTH           = 6,
  parameter int EST_CHAN_DEPTH    = 30,
  parameter int EST_CHANNEL_WIDTH = 8,
  parameter int SH_DEPTH          = 18
) (
  input  symbol_t                       hist [SH_DEPTH],
  input  logic signed [EST_CHANNEL_WIDTH-1:0] est_channel [EST_CHAN_DEPTH],
  input  logic signed [B_WIDTH-1:0]     rse_vals [B_LEN],
  output logic signed [B_WIDTH-1:0]     precomputed_static_val [B_LEN]
);
  localparam int OFFSET = static_offset(B_LEN, H_DEPTH, S_LEN);
  logic signed [B_WIDTH-1:0] static_val [B_LEN];
  int acc;
  always_comb begin
    acc = 0;
    for (int k = 0; k < B_LEN; k++) begin
      acc = 0;
      // taps falling outside the estimated channel contribute nothing
      for (int j = 0; j < SH_DEPTH; j++)
        if (j + OFFSET - k >= 0 && j + OFFSET - k < EST_CHAN_DEPTH)
          acc += int'(hist[j]) * int'(est_channel[j + OFFSET - k]);
      static_val[k] = B_WIDTH'(saturate(acc >>> 1, B_WIDTH));
      precomputed_static_val[k] = B_WIDTH'(saturate(int'(static_val[k]) + int'(rse_vals[k]), B_WIDTH));
    end
  end
endmodule

// File: rtl/viterbi_static_tracker.sv
// viterbi_static_tracker: commits the min-energy state's newest symbols and precomputes static ISI.
// Define VITERBI_STATIC_TRACE_EN to print a trace line on every run step.
module viterbi_static_tracker
  import viterbi_pkg::*;
#(
  parameter int B_WIDTH           = 8,
  parameter int B_LEN             = 2,
  parameter int S_LEN             = 2,
  parameter int H_DEPTH           = 6,
  parameter int EST_CHAN_DEPTH    = 30,
  parameter int EST_CHANNEL_WIDTH = 8,
  parameter int N_S               = 7,
  parameter int SH_DEPTH          = 18
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          run,
  input  logic [2*B_WIDTH-1:0]          state_energies [N_S],
  input  logic signed [1:0]             state_histories [N_S][B_LEN],
  input  logic signed [EST_CHANNEL_WIDTH-1:0] est_channel [EST_CHAN_DEPTH],
  input  logic signed [B_WIDTH-1:0]     rse_vals [B_LEN],
  output logic signed [1:0]             final_symbols [B_LEN],
  output logic signed [B_WIDTH-1:0]     precomputed_static_val [B_LEN],
  output logic [2*B_WIDTH-1:0]          global_static_energy
);
  symbol_t hist_q [SH_DEPTH];
  symbol_t hist_d [SH_DEPTH];
  logic [2*B_WIDTH-1:0] energy_q, energy_d;
  int best;
  // strict less-than keeps the lowest index on ties
  always_comb begin
    best = 0;
    for (int i = 1; i < N_S; i++)
      if (state_energies[i] < state_energies[best]) best = i;
  end
  always_comb begin
    for (int i = 0; i < B_LEN; i++) hist_d[i] = run ? state_histories[best][i] : hist_q[i];
    for (int i = B_LEN; i < SH_DEPTH; i++) hist_d[i] = run ? hist_q[i - B_LEN] : hist_q[i];
    energy_d = run ? state_energies[best] : energy_q;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hist_q   <= '{default: '0};
      energy_q <= '0;
    end else begin
      hist_q   <= hist_d;
      energy_q <= energy_d;
    end
  end
  always_comb for (int k = 0; k < B_LEN; k++) final_symbols[k] = hist_q[k];
  assign global_static_energy = energy_q;
  static_conv #(
    .B_WIDTH(B_WIDTH), .B_LEN(B_LEN), .S_LEN(S_LEN), .H_DEPTH(H_DEPTH),
    .EST_CHAN_DEPTH(EST_CHAN_DEPTH), .EST_CHANNEL_WIDTH(EST_CHANNEL_WIDTH), .SH_DEPTH(SH_DEPTH)
  ) u_conv (
    .hist(hist_q),
    .est_channel(est_channel),
    .rse_vals(rse_vals),
    .precomputed_static_val(precomputed_static_val)
  );
`ifdef VITERBI_STATIC_TRACE_EN
  always_ff @(posedge clk) begin
    if (rst_n && run) begin
      $write("%m pre/rse/static:");
      for (int k = 0; k < B_LEN; k++)
        $write(" %0d/%0d/%0d", precomputed_static_val[k], rse_vals[k], u_conv.static_val[k]);
      $write(" hist:");
      for (int i = 0; i < SH_DEPTH; i++) $write(" %0d", hist_q[i]);
      $display("");
    end
  end
`else
`endif
endmodule

// File: tb/tb_viterbi_static_tracker.sv
// tb_viterbi_static_tracker: directed plan plus randomized run/reset traffic checked against a behavioural model
module tb_viterbi_static_tracker;
  logic clk = 0, rst_n = 0, run = 0;
  logic [15:0] se [7];
  logic signed [1:0] sh [7][2];
  logic signed [7:0] ch [30];
  logic signed [7:0] rse [2];
  logic signed [1:0] fs [2];
  logic signed [7:0] pre [2];
  logic [15:0] gse;
  int n_tests = 0, n_fail = 0;
  int mh [18];
  int me;

  viterbi_static_tracker dut (
    .clk(clk), .rst_n(rst_n), .run(run),
    .state_energies(se), .state_histories(sh), .est_channel(ch), .rse_vals(rse),
    .final_symbols(fs), .precomputed_static_val(pre), .global_static_energy(gse)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input int got, input int exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic int clamp8(input int v);
    return v > 127 ? 127 : v < -128 ? -128 : v;
  endfunction

  function automatic int model_pre(input int k);
    int acc = 0;
    for (int j = 0; j < 18; j++) begin
      int t = j + 10 - k;
      if (t >= 0 && t < 30) acc += mh[j] * int'(ch[t]);
    end
    return clamp8(clamp8(acc >>> 1) + int'(rse[k]));
  endfunction

  task automatic model_reset();
    foreach (mh[i]) mh[i] = 0;
    me = 0;
  endtask

  task automatic model_commit();
    int mn = 1 << 20;
    int b = 0;
    foreach (se[i]) if (int'(se[i]) < mn) mn = int'(se[i]);
    for (int i = 6; i >= 0; i--) if (int'(se[i]) == mn) b = i;
    for (int i = 17; i >= 2; i--) mh[i] = mh[i - 2];
    mh[0] = int'(sh[b][0]);
    mh[1] = int'(sh[b][1]);
    me = mn;
  endtask

  task automatic check_all(input string tag);
    for (int k = 0; k < 2; k++) begin
      check({tag, "_fs"}, int'(fs[k]), mh[k]);
      check({tag, "_pre"}, int'(pre[k]), model_pre(k));
    end
    check({tag, "_energy"}, int'(gse), me);
  endtask

  task automatic cyc(input logic r, input string tag);
    run = r;
    @(posedge clk);
    if (r) model_commit();
    #1;
    check_all(tag);
  endtask

  task automatic set_all(input int e, input int h0, input int h1);
    for (int i = 0; i < 7; i++) begin
      se[i] = 16'(e);
      sh[i][0] = 2'(h0);
      sh[i][1] = 2'(h1);
    end
  endtask

  task automatic randomize_inputs();
    for (int i = 0; i < 7; i++) begin
      se[i] = 16'($urandom_range(0, 15));
      sh[i][0] = 2'($urandom_range(0, 3));
      sh[i][1] = 2'($urandom_range(0, 3));
    end
    foreach (ch[i]) ch[i] = 8'($urandom);
    rse[0] = 8'($urandom);
    rse[1] = 8'($urandom);
  endtask

  initial begin
    int sf0, sf1, sp0, sp1, sg;
    set_all(100, 0, 0);
    foreach (ch[i]) ch[i] = 8'($urandom);
    rse[0] = 3;
    rse[1] = -3;
    model_reset();
    #1;
    check("rst_fs0", int'(fs[0]), 0);
    check("rst_fs1", int'(fs[1]), 0);
    check("rst_energy", int'(gse), 0);
    check("rst_pre0", int'(pre[0]), 3);
    check("rst_pre1", int'(pre[1]), -3);
    @(negedge clk);
    rst_n = 1;

    se = '{50, 40, 30, 20, 10, 60, 70};
    sh[4][0] = 1;
    sh[4][1] = -1;
    cyc(1, "sel");
    check("sel_fs0", int'(fs[0]), 1);
    check("sel_fs1", int'(fs[1]), -1);
    check("sel_energy", int'(gse), 10);

    set_all(100, 0, 0);
    se[2] = 5; sh[2][0] = -1; sh[2][1] = -1;
    se[5] = 5; sh[5][0] = 1;  sh[5][1] = 1;
    cyc(1, "tie");
    check("tie_fs0", int'(fs[0]), -1);
    check("tie_fs1", int'(fs[1]), -1);

    foreach (ch[i]) ch[i] = 0;
    ch[10] = 8;
    rse[0] = 3;
    rse[1] = -3;
    set_all(7, 1, -1);
    cyc(1, "conv");
    check("conv_pre0", int'(pre[0]), 7);
    check("conv_pre1", int'(pre[1]), -7);

    set_all(9, 1, 1);
    cyc(1, "shift_a");
    set_all(9, -1, -1);
    cyc(1, "shift_b");
    check("shift_h0", int'(dut.hist_q[0]), -1);
    check("shift_h1", int'(dut.hist_q[1]), -1);
    check("shift_h2", int'(dut.hist_q[2]), 1);
    check("shift_h3", int'(dut.hist_q[3]), 1);
    sf0 = int'(fs[0]); sf1 = int'(fs[1]); sp0 = int'(pre[0]); sp1 = int'(pre[1]); sg = int'(gse);
    for (int c = 0; c < 5; c++) begin
      for (int i = 0; i < 7; i++) begin
        se[i] = 16'($urandom_range(0, 3));
        sh[i][0] = 2'($urandom);
        sh[i][1] = 2'($urandom);
      end
      cyc(0, "hold");
      check("hold_fs0", int'(fs[0]), sf0);
      check("hold_fs1", int'(fs[1]), sf1);
      check("hold_pre0", int'(pre[0]), sp0);
      check("hold_pre1", int'(pre[1]), sp1);
      check("hold_energy", int'(gse), sg);
    end

    foreach (ch[i]) ch[i] = 127;
    rse[0] = 10;
    rse[1] = -10;
    set_all(1, 1, 1);
    for (int c = 0; c < 9; c++) cyc(1, "sat_fill");
    check("sat_pre0", int'(pre[0]), 127);
    check("sat_pre1", int'(pre[1]), 117);

    for (int c = 0; c < 400; c++) begin
      randomize_inputs();
      #1;
      check_all("comb");
      cyc(1'($urandom_range(0, 3) != 0), "rand");
      if ($urandom_range(0, 39) == 0) begin
        #2;
        rst_n = 0;
        model_reset();
        #1;
        check_all("async_rst");
        @(negedge clk);
        rst_n = 1;
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
